// File: rtl/dot_product_acc.sv
// dot_product_acc: accumulation stage behind an external 8x8 multiplier.
// Registers operand pairs toward the multiplier, tracks each beat through the
// multiplier's fixed latency with a valid/last delay line, sums the aligned
// products and emits one dot-product result (sum, count, overflow) per vector
// as a single-cycle pulse.
module dot_product_acc #(
    parameter int MUL_LAT = 4,
    parameter int ACC_W   = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [15:0]      mul_result,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_ovf
);

    // Operand registers feeding the multiplier
    logic [7:0]       mul_a_q;
    logic [7:0]       mul_b_q;

    // Delay line: bit i is stage i; stage MUL_LAT lines up with mul_result
    logic [MUL_LAT:0] vld_q;
    logic [MUL_LAT:0] lst_q;

    // Running vector state
    logic [ACC_W-1:0] acc_q,  acc_d;
    logic [7:0]       cnt_q,  cnt_d;
    logic             ovf_q,  ovf_d;

    // Result registers
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q,   out_sum_d;
    logic [7:0]       out_count_q, out_count_d;
    logic             out_ovf_q,   out_ovf_d;

    // Aligned beat and the candidate next values computed from it
    logic             beat_vld;
    logic             beat_last;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] sum_nxt;
    logic             wrap;
    logic [7:0]       cnt_nxt;
    logic             ovf_nxt;

    // Add a zero-extended product to the accumulator, returning {carry, sum}
    function automatic logic [ACC_W:0] add_carry(input logic [ACC_W-1:0] acc,
                                                 input logic [15:0]      prod);
        return {1'b0, acc} + (ACC_W+1)'(prod);
    endfunction

    // Element counter increment that sticks at 255
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

    assign beat_vld  = vld_q[MUL_LAT];
    assign beat_last = lst_q[MUL_LAT];

    // Operand stage: capture accepted beats, hold operands through bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else if (in_valid) begin
            mul_a_q <= in_a;
            mul_b_q <= in_b;
        end
    end

    // Delay line: shift {valid, last} alongside the multiplier pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q <= {vld_q[MUL_LAT-1:0], in_valid};
            lst_q <= {lst_q[MUL_LAT-1:0], in_valid & in_last};
        end
    end

    // Accumulate the aligned product; close the vector on an aligned last beat
    always_comb begin
        sum_ext     = add_carry(acc_q, mul_result);
        sum_nxt     = sum_ext[ACC_W-1:0];
        wrap        = sum_ext[ACC_W];
        cnt_nxt     = sat_inc(cnt_q);
        ovf_nxt     = ovf_q | wrap;

        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (beat_vld) begin
            if (beat_last) begin
                out_valid_d = 1'b1;
                out_sum_d   = sum_nxt;
                out_count_d = cnt_nxt;
                out_ovf_d   = ovf_nxt;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d       = sum_nxt;
                cnt_d       = cnt_nxt;
                ovf_d       = ovf_nxt;
            end
        end
    end

    // Accumulator state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Result register: pulse valid for one cycle, hold fields between pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule
